cpu_program_loader: RTL
=======================

// Module: cpu_program_loader
// PURPOSE
//  Transmit side of the CPU instruction-load interface (LoadInstructions/Instruction/Reset).
//  Accepts a big-endian byte stream, e.g. from a UART bridge, and packs it into 32-bit words.
//  Streams the words into the pipelined CPU's instruction memory, then pulses CpuReset so the CPU runs the new program.
//  Sits between the host byte link and the CPU top-level.
// PARAMETERS
//  MAX_WORDS   64  instruction memory depth in words; program length limit
//  RST_CYCLES  1   CpuReset high cycles in the release phase (>=1)
//  CNT_W       $clog2(MAX_WORDS)+1  word counter width (derived, localparam)
// PORTS
//  clk               in   1      single clock, rising edge
//  Reset_n           in   1      asynchronous, active-low reset
//  start             in   1      pulse: begin a new program load
//  byte_valid        in   1      byte source has data
//  byte_data         in   8      program byte; first byte of a word = Instruction[31:24]
//  byte_last         in   1      qualifies the final byte of the program
//  byte_ready        out  1      loader accepts byte (handshake: valid&ready)
//  LoadInstructions  out  1      CPU write strobe; one instruction written per high cycle
//  Instruction       out  32     instruction word, valid while LoadInstructions=1
//  CpuReset          out  1      CPU reset, active-high
//  word_count        out  CNT_W  words emitted in current load
//  busy              out  1      PRE/LOAD/RELEASE in progress
//  done              out  1      program loaded, CPU running
//  overflow          out  1      program exceeded MAX_WORDS
//  checksum          out  32     XOR of emitted words (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: byte_ready=0, LoadInstructions=0, Instruction=0, CpuReset=1, word_count=0,
//   busy=0, done=0, overflow=0, checksum=0; FSM=IDLE.
//  FSM states: IDLE, PRE, LOAD, RELEASE, RUN, ERR. All outputs are registered.
//  IDLE: CpuReset=1. start -> PRE.
//  PRE (1 cycle): CpuReset=1; clears word_count, byte index, checksum, overflow, done. -> LOAD.
//  LOAD: CpuReset=0; byte_ready=1. Accepted bytes shift into the packer MSB-first.
//   4th byte accepted in cycle N -> LoadInstructions=1, Instruction=word in cycle N+1, exactly one cycle.
//   word_count increments in that same cycle.
//   LoadInstructions is never high without a fresh word; gaps in byte_valid leave it low (CPU stalls its write pointer).
//   byte_last on byte k<3: the partial word is emitted with low bytes zero-padded; then -> RELEASE.
//   byte_last on byte 3: word emitted normally; then -> RELEASE.
//   byte_last with word_count already == MAX_WORDS is an overflow case (see below).
//  Overflow: a byte is accepted while word_count==MAX_WORDS. The byte is dropped -> ERR.
//  ERR: overflow=1, CpuReset=1, byte_ready=0. start -> PRE.
//  RELEASE: LoadInstructions=0, byte_ready=0, CpuReset=1 for RST_CYCLES cycles -> RUN.
//  RUN: CpuReset=0, done=1. start -> PRE, and PRE drives CpuReset=1, halting the CPU.
//  start is ignored in PRE/LOAD/RELEASE. byte_valid is ignored outside LOAD.
//  Reset_n low at any time: all outputs return to reset values immediately; a partial word is discarded.
//  Simultaneous byte handshake and start in RUN/ERR cannot occur, because byte_ready=0.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: checksum ^= Instruction on every LoadInstructions cycle.
//   checksum is held stable from RELEASE onward until the next PRE.
//  LOADER_CHECKSUM_EN undefined: no XOR logic is built; checksum is tied to 32'h0.
// STRUCTURE
//  Shared package cpu_loader_pkg holds:
//   - FSM state encoding (3-bit localparams)
//   - WORD_W=32, BYTE_W=8, BYTES_PER_WORD=4
//  Sub-module byte_packer: 8->32 shift assembler with a 2-bit byte index.
//   Its outputs are word_ready and word, with zero-pad on flush (byte_last).
//  Top level: FSM, counters, release timer, optional checksum.
// TESTING
//  1: start; bytes 20 01 01 A7, 20 02 00 5C(last).
//     -> LoadInstructions two single cycles, with Instruction 0x200101A7 then 0x2002005C.
//     -> CpuReset=1 for RST_CYCLES, then done=1, word_count=2.
//  2: byte_valid with gaps of 3 idle cycles between bytes.
//     -> each word strobed exactly once, 1 cycle after its 4th byte; no spurious LoadInstructions.
//  3: bytes AB CD(last).
//     -> Instruction=0xABCD0000 emitted once, then RELEASE/RUN.
//  4: MAX_WORDS=4, stream 17 bytes with no last.
//     -> 4 words emitted, overflow=1, CpuReset held 1, byte_ready=0.
//     -> start returns to PRE with overflow cleared.
//  5: Reset_n low for 2 cycles after 2 bytes of word 1.
//     -> outputs return to reset values at once (CpuReset=1, word_count=0).
//     -> a new start+load of 0x200101A7 is emitted correctly.
//  6: LOADER_CHECKSUM_EN, load 0x200101A7, 0x2002005C -> checksum=0x000301FB.
//     -> same load without the macro gives checksum=0.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the CPU program loader: FSM encoding and word/byte geometry.
package cpu_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

endpackage

// File: rtl/cpu_program_loader_byte_packer.sv
// Big-endian 8->32 word assembler; a flush on byte_last zero-pads the unfilled low bytes.
module byte_packer
    import cpu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    input  logic              byte_last_i,
    output logic              word_ready_c_o,
    output logic [WORD_W-1:0] word_c_o
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sh_q, sh_d;

    // Word as it would look with the current byte merged in at its big-endian slot.
    always_comb begin
        word_c_o = sh_q;
        case (idx_q)
            2'd0:    word_c_o[31:24] = byte_data_i;
            2'd1:    word_c_o[23:16] = byte_data_i;
            2'd2:    word_c_o[15:8]  = byte_data_i;
            default: word_c_o[7:0]   = byte_data_i;
        endcase
        word_ready_c_o = byte_en_i && ((idx_q == IDX_W'(BYTES_PER_WORD - 1)) || byte_last_i);
    end

    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        if (clear_i) begin
            idx_d = '0;
            sh_d  = '0;
        end else if (byte_en_i) begin
            if (word_ready_c_o) begin
                idx_d = '0;
                sh_d  = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                sh_d  = word_c_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Streams a host byte program into the CPU instruction memory, then releases the CPU from reset.
// Build option: LOADER_CHECKSUM_EN adds a running XOR of emitted words on checksum.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter  int unsigned MAX_WORDS  = 64,
    parameter  int unsigned RST_CYCLES = 1,
    localparam int unsigned CNT_W      = $clog2(MAX_WORDS) + 1
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              LoadInstructions,
    output logic [WORD_W-1:0] Instruction,
    output logic              CpuReset,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [WORD_W-1:0] checksum
);

    localparam int unsigned REL_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic              ready_q, ready_d;
    logic              load_q, load_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              accept_c, ovf_hit_c, pack_en_c;
    logic              word_ready_c;
    logic [WORD_W-1:0] word_c;

    assign accept_c  = ready_q && byte_valid;
    assign ovf_hit_c = accept_c && (wc_q == CNT_W'(MAX_WORDS));
    assign pack_en_c = accept_c && !ovf_hit_c;

    byte_packer u_packer (
        .clk            (clk),
        .rst_n          (Reset_n),
        .clear_i        (state_q == ST_PRE),
        .byte_en_i      (pack_en_c),
        .byte_data_i    (byte_data),
        .byte_last_i    (byte_last),
        .word_ready_c_o (word_ready_c),
        .word_c_o       (word_c)
    );

    // Next state; last_q marks the one drain cycle in LOAD where the final word is strobed.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rel_d   = rel_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PRE;
            ST_PRE: begin
                state_d = ST_LOAD;
                last_d  = 1'b0;
            end
            ST_LOAD: begin
                if (ovf_hit_c) begin
                    state_d = ST_ERR;
                end else if (last_q) begin
                    state_d = ST_RELEASE;
                    rel_d   = '0;
                end else if (pack_en_c && byte_last) begin
                    last_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(RST_CYCLES - 1)) state_d = ST_RUN;
                else                                 rel_d   = rel_q + REL_W'(1);
            end
            ST_RUN:  if (start) state_d = ST_PRE;
            ST_ERR:  if (start) state_d = ST_PRE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered so they line up with state_q.
    always_comb begin
        ready_d   = (state_d == ST_LOAD) && !last_d;
        load_d    = word_ready_c;
        instr_d   = word_ready_c ? word_c : instr_q;
        cpu_rst_d = !((state_d == ST_LOAD) || (state_d == ST_RUN));
        busy_d    = (state_d == ST_PRE) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);
        done_d    = (state_d == ST_RUN);
        ovf_d     = (state_d == ST_ERR);
        wc_d      = wc_q;
        if (state_d == ST_PRE)  wc_d = '0;
        else if (word_ready_c)  wc_d = wc_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b0;
            rel_q     <= '0;
            ready_q   <= 1'b0;
            load_q    <= 1'b0;
            instr_q   <= '0;
            cpu_rst_q <= 1'b1;
            wc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rel_q     <= rel_d;
            ready_q   <= ready_d;
            load_q    <= load_d;
            instr_q   <= instr_d;
            cpu_rst_q <= cpu_rst_d;
            wc_q      <= wc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (state_d == ST_PRE)  cks_d = '0;
        else if (word_ready_c)  cks_d = cks_q ^ word_c;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) cks_q <= '0;
        else          cks_q <= cks_d;
    end

    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    assign byte_ready       = ready_q;
    assign LoadInstructions = load_q;
    assign Instruction      = instr_q;
    assign CpuReset         = cpu_rst_q;
    assign word_count       = wc_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = ovf_q;

endmodule
